hdmi_tmds_encoder_n: RTL

- Parametrised N-channel TMDS 8b/10b encoder in the pixel clock domain; successor to the fixed 3-channel RGB encoder stage of the HDMI path.
- Takes per-channel 8-bit pixel data, per-channel 2-bit control and an active-area flag.
- Emits DC-balanced 10-bit symbols to the serialiser.
- Adds a configurable channel count, an optional output register and optional HDMI video preamble/guard-band insertion.

---
 rtl/hdmi_tmds_encoder_n.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/hdmi_tmds_encoder_n.sv
// -----------------------------------------------------------------------------
// hdmi_tmds_encoder_n
//   N-channel TMDS 8b/10b encoder in the pixel clock domain. Every channel is
//   encoded independently with its own running disparity counter; all channels
//   share one pipeline so their symbols stay cycle-aligned.
//
//   The stream has no valid/ready handshake: one symbol per channel is accepted
//   and produced on every clock, with no backpressure and no stalls.
//
//   Optional build macro: HDMI_GUARD_BAND_EN
//     Defined   : inputs pass through a 10-deep delay line; the 10 blanking
//                 cycles in front of each video period are replaced by the
//                 HDMI video preamble (8 cycles) and leading guard band (2).
//     Undefined : pure DVI encoding, no delay line.
//
// Parameters
//   NUM_CH  : number of TMDS data channels (1..4)
//   OUT_REG : 0/1, adds one output register stage
//
// Ports
//   i_p_clk        pixel clock
//   i_resetn       asynchronous active-low reset
//   i_data         8 bits per channel, channel k at [8k+:8]
//   i_ctrl         {C1,C0} per channel at [2k+:2]; channel 0 = {vsync,hsync}
//   i_active_area  1 = video data period, 0 = control period
//   o_tmds         10-bit symbol per channel at [10k+:10], bit 0 sent first
//   o_active_area  i_active_area aligned with o_tmds
//
// Latency: 2 + OUT_REG cycles (12 + OUT_REG with HDMI_GUARD_BAND_EN).
// -----------------------------------------------------------------------------
module hdmi_tmds_encoder_n #(
  parameter int NUM_CH  = 3,
  parameter int OUT_REG = 1
) (
  input  logic                 i_p_clk,
  input  logic                 i_resetn,
  input  logic [8*NUM_CH-1:0]  i_data,
  input  logic [2*NUM_CH-1:0]  i_ctrl,
  input  logic                 i_active_area,
  output logic [10*NUM_CH-1:0] o_tmds,
  output logic                 o_active_area
);

  localparam logic [9:0] CTRL_SYM_00 = 10'h354;
  localparam logic [9:0] CTRL_SYM_01 = 10'h0AB;
  localparam logic [9:0] CTRL_SYM_10 = 10'h154;
  localparam logic [9:0] CTRL_SYM_11 = 10'h2AB;

  // Transition-minimised word (stage 1 of the TMDS algorithm).
  function automatic logic [8:0] tmds_qm(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1 = '0;
    for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, d[i]};
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~use_xnor;
    return q;
  endfunction

  // Leading guard-band symbol for a channel; channels without one idle at 354.
  function automatic logic [9:0] guard_sym(input int k);
    if (k == 1)      return 10'h133;
    else if (k <= 2) return 10'h2CC;
    else             return CTRL_SYM_00;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage-0 front end: either the raw inputs or the guard-band delay line.
  // ---------------------------------------------------------------------------
  logic [8*NUM_CH-1:0] s0_data;
  logic [2*NUM_CH-1:0] s0_ctrl;
  logic                s0_act;
  logic                s0_gb;    // 1 = emit guard-band symbols this cycle

`ifdef HDMI_GUARD_BAND_EN
  localparam int DL_DEPTH = 10;

  logic [8*NUM_CH-1:0] dl_data_q [DL_DEPTH];
  logic [2*NUM_CH-1:0] dl_ctrl_q [DL_DEPTH];
  logic [DL_DEPTH-1:0] dl_act_q;
  logic [3:0]          gb_cnt_q, gb_cnt_d, gb_cur;
  logic                gb_run_q, gb_run_d, gb_cur_valid;

  always_ff @(posedge i_p_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      for (int i = 0; i < DL_DEPTH; i++) begin
        dl_data_q[i] <= '0;
        dl_ctrl_q[i] <= '0;
      end
      dl_act_q <= '0;
      gb_cnt_q <= '0;
      gb_run_q <= 1'b0;
    end else begin
      dl_data_q[0] <= i_data;
      dl_ctrl_q[0] <= i_ctrl;
      for (int i = 1; i < DL_DEPTH; i++) begin
        dl_data_q[i] <= dl_data_q[i-1];
        dl_ctrl_q[i] <= dl_ctrl_q[i-1];
      end
      dl_act_q <= {dl_act_q[DL_DEPTH-2:0], i_active_area};
      gb_cnt_q <= gb_cnt_d;
      gb_run_q <= gb_run_d;
    end
  end

  // A rising edge at the delay-line input means video reaches stage 1 in
  // exactly 10 cycles, so the samples leaving the delay line now and over the
  // next 9 cycles are the blanking slots available for preamble/guard band.
  // dl_act_q[0] holds the previous cycle's i_active_area.
  always_comb begin
    gb_cur_valid = 1'b0;
    gb_cur       = '0;
    if (i_active_area && !dl_act_q[0]) begin
      gb_cur_valid = 1'b1;
      gb_cur       = 4'd0;
    end else if (gb_run_q) begin
      gb_cur_valid = 1'b1;
      gb_cur       = gb_cnt_q;
    end
    gb_run_d = gb_cur_valid && (gb_cur != 4'd9);
    gb_cnt_d = gb_run_d ? gb_cur + 4'd1 : 4'd0;

    s0_data = dl_data_q[DL_DEPTH-1];
    s0_ctrl = dl_ctrl_q[DL_DEPTH-1];
    s0_act  = dl_act_q[DL_DEPTH-1];
    s0_gb   = 1'b0;
    // Video already at the delay-line output is never displaced.
    if (gb_cur_valid && !s0_act) begin
      if (gb_cur <= 4'd7) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (k == 1)      s0_ctrl[2*k+:2] = 2'b01;
          else if (k == 2) s0_ctrl[2*k+:2] = 2'b00;
        end
      end else begin
        s0_gb = 1'b1;
      end
    end
  end
`else
  always_comb begin
    s0_data = i_data;
    s0_ctrl = i_ctrl;
    s0_act  = i_active_area;
    s0_gb   = 1'b0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Shared per-stage flags.
  // ---------------------------------------------------------------------------
  logic [2*NUM_CH-1:0]  s1_ctrl_q;
  logic                 s1_act_q;
  logic                 s1_gb_q;
  logic                 s2_act_q;
  logic [10*NUM_CH-1:0] s2_tmds;

  always_ff @(posedge i_p_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      s1_ctrl_q <= '0;
      s1_act_q  <= 1'b0;
      s1_gb_q   <= 1'b0;
      s2_act_q  <= 1'b0;
    end else begin
      s1_ctrl_q <= s0_ctrl;
      s1_act_q  <= s0_act;
      s1_gb_q   <= s0_gb;
      s2_act_q  <= s1_act_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel stage 1 (q_m) and stage 2 (DC balance / control symbols).
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [8:0]        qm_q;
    logic [3:0]        n1;
    logic signed [4:0] diff;      // n1 - n0 of q_m[7:0]
    logic signed [4:0] cnt_q, cnt_d;
    logic [9:0]        sym_q, sym_d;

    always_ff @(posedge i_p_clk or negedge i_resetn) begin
      if (!i_resetn) qm_q <= '0;
      else           qm_q <= tmds_qm(s0_data[8*k+:8]);
    end

    always_comb begin
      n1 = '0;
      for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, qm_q[i]};
      // n1 - n0 = 2*(n1 - 4); stays within -8..8, so 5 bits suffice.
      diff  = $signed(({1'b0, n1} - 5'd4) << 1);
      sym_d = CTRL_SYM_00;
      cnt_d = cnt_q;
      if (!s1_act_q) begin
        cnt_d = 5'sd0;
        if (s1_gb_q) begin
          sym_d = guard_sym(k);
        end else begin
          case (s1_ctrl_q[2*k+:2])
            2'b00:   sym_d = CTRL_SYM_00;
            2'b01:   sym_d = CTRL_SYM_01;
            2'b10:   sym_d = CTRL_SYM_10;
            default: sym_d = CTRL_SYM_11;
          endcase
        end
      end else if ((cnt_q == 5'sd0) || (diff == 5'sd0)) begin
        sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
        cnt_d = qm_q[8] ? cnt_q + diff : cnt_q - diff;
      end else if (((cnt_q > 5'sd0) && (diff > 5'sd0)) ||
                   ((cnt_q < 5'sd0) && (diff < 5'sd0))) begin
        sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
        cnt_d = cnt_q + $signed({3'b000, qm_q[8], 1'b0}) - diff;
      end else begin
        sym_d = {1'b0, qm_q[8], qm_q[7:0]};
        cnt_d = cnt_q - $signed({3'b000, ~qm_q[8], 1'b0}) + diff;
      end
    end

    always_ff @(posedge i_p_clk or negedge i_resetn) begin
      if (!i_resetn) begin
        sym_q <= CTRL_SYM_00;
        cnt_q <= 5'sd0;
      end else begin
        sym_q <= sym_d;
        cnt_q <= cnt_d;
      end
    end

    assign s2_tmds[10*k+:10] = sym_q;
  end

  // ---------------------------------------------------------------------------
  // Optional output register.
  // ---------------------------------------------------------------------------
  if (OUT_REG != 0) begin : g_out_reg
    logic [10*NUM_CH-1:0] out_tmds_q;
    logic                 out_act_q;

    always_ff @(posedge i_p_clk or negedge i_resetn) begin
      if (!i_resetn) begin
        out_tmds_q <= {NUM_CH{CTRL_SYM_00}};
        out_act_q  <= 1'b0;
      end else begin
        out_tmds_q <= s2_tmds;
        out_act_q  <= s2_act_q;
      end
    end

    assign o_tmds        = out_tmds_q;
    assign o_active_area = out_act_q;
  end else begin : g_no_out_reg
    assign o_tmds        = s2_tmds;
    assign o_active_area = s2_act_q;
  end

endmodule
